// File: rtl/matmul_seq_pkg.sv
// Shared types and width helpers for the K-tile matmul sequencer.
// Holds the FSM encoding and default-configuration widths.
package matmul_seq_pkg;

    localparam int DATA_WIDTH_DEF       = 8;
    localparam int A_COLUMNS_B_ROWS_DEF = 4;
    localparam int MAX_K_TILES_DEF      = 16;

    function automatic int calc_c_data_width(input int data_width, input int k_depth);
        return 2 * data_width + $clog2(k_depth);
    endfunction

    // Sum of MAX_K_TILES multiplier outputs needs log2(MAX_K_TILES) extra bits.
    function automatic int calc_acc_width(input int c_data_width, input int max_k_tiles);
        return c_data_width + $clog2(max_k_tiles);
    endfunction

    localparam int C_DATA_WIDTH = calc_c_data_width(DATA_WIDTH_DEF, A_COLUMNS_B_ROWS_DEF);
    localparam int ACC_WIDTH    = calc_acc_width(C_DATA_WIDTH, MAX_K_TILES_DEF);
    localparam int K_CNT_WIDTH  = $clog2(MAX_K_TILES_DEF + 1);

    typedef logic [K_CNT_WIDTH-1:0] k_cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/matmul_accumulator.sv
// Element-wise unsigned accumulator for partial C tiles; 1-cycle add, no backpressure.
// clear wins over add; synchronous active-low reset zeroes every element.
module matmul_accumulator
    import matmul_seq_pkg::*;
#(
    parameter int N_ELEM       = 40,
    parameter int C_DATA_WIDTH = 18,
    parameter int ACC_WIDTH    = 22
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    clear,
    input  logic                    add,
    input  logic [C_DATA_WIDTH-1:0] addend [N_ELEM],
    output logic [ACC_WIDTH-1:0]    acc    [N_ELEM]
);

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N_ELEM; i++) begin
            if (!reset_ni || clear) begin
                acc[i] <= '0;
            end else if (add) begin
                acc[i] <= acc[i] + ACC_WIDTH'(addend[i]);
            end
        end
    end

endmodule

// File: rtl/matmul_k_tile_sequencer.sv
// Streams NUM_K A/B slices through a 1-cycle multiplier and sums the partial C tiles.
// Result N+2 cycles after job accept; result held until res_ready_i, new jobs stalled meanwhile.
module matmul_k_tile_sequencer
    import matmul_seq_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int A_ROWS           = 8,
    parameter int B_COLUMNS        = 5,
    parameter int A_COLUMNS_B_ROWS = 4,
    parameter int MAX_K_TILES      = 16,
    parameter int ID_WIDTH         = 4,
    localparam int C_DW  = calc_c_data_width(DATA_WIDTH, A_COLUMNS_B_ROWS),
    localparam int ACC_W = calc_acc_width(C_DW, MAX_K_TILES),
    localparam int KW    = $clog2(MAX_K_TILES + 1),
    localparam int NA    = A_ROWS * A_COLUMNS_B_ROWS,
    localparam int NB    = A_COLUMNS_B_ROWS * B_COLUMNS,
    localparam int NC    = A_ROWS * B_COLUMNS
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  job_valid_i,
    output logic                  job_ready_o,
    input  logic [KW-1:0]         num_k_tiles_i,
    input  logic [ID_WIDTH-1:0]   job_id_i,
    input  logic                  tile_valid_i,
    output logic                  tile_ready_o,
    input  logic [DATA_WIDTH-1:0] a_tile_i [NA],
    input  logic [DATA_WIDTH-1:0] b_tile_i [NB],
    output logic                  mm_valid_o,
    output logic [DATA_WIDTH-1:0] mm_a_o   [NA],
    output logic [DATA_WIDTH-1:0] mm_b_o   [NB],
    input  logic                  mm_valid_i,
    input  logic [C_DW-1:0]       mm_c_i   [NC],
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [ID_WIDTH-1:0]   res_id_o,
    output logic [ACC_W-1:0]      res_c_o  [NC]
);

    localparam logic [KW-1:0] MAX_K = KW'(MAX_K_TILES);

    state_e        state_q, state_nxt;
    logic [KW-1:0] num_q, issued_q, returned_q;
    logic [KW-1:0] num_sat;
    logic          job_fire, ret_fire, ret_last;

    assign num_sat    = (num_k_tiles_i > MAX_K) ? MAX_K : num_k_tiles_i;
    assign job_fire   = job_valid_i & job_ready_o;
    assign mm_valid_o = tile_valid_i & tile_ready_o;
    assign mm_a_o     = a_tile_i;
    assign mm_b_o     = b_tile_i;

    // Returns arriving outside ISSUE or beyond the job's count are leftovers from an aborted job.
    assign ret_fire = mm_valid_i && (state_q == ISSUE) && (returned_q != num_q);
    assign ret_last = (returned_q + KW'(1)) == num_q;

    always_comb begin
        state_nxt    = state_q;
        job_ready_o  = 1'b0;
        tile_ready_o = 1'b0;
        res_valid_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                job_ready_o = reset_ni;
                if (job_valid_i && reset_ni) begin
                    state_nxt = (num_sat == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                tile_ready_o = reset_ni && (issued_q < num_q);
                if (ret_fire && ret_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                res_valid_o = reset_ni;
                if (reset_ni && res_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            num_q      <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            res_id_o   <= '0;
        end else begin
            state_q <= state_nxt;
            if (job_fire) begin
                num_q      <= num_sat;
                issued_q   <= '0;
                returned_q <= '0;
                res_id_o   <= job_id_i;
            end else begin
                if (mm_valid_o) begin
                    issued_q <= issued_q + KW'(1);
                end
                if (ret_fire) begin
                    returned_q <= returned_q + KW'(1);
                end
            end
        end
    end

    matmul_accumulator #(
        .N_ELEM       (NC),
        .C_DATA_WIDTH (C_DW),
        .ACC_WIDTH    (ACC_W)
    ) u_acc (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear    (job_fire),
        .add      (ret_fire),
        .addend   (mm_c_i),
        .acc      (res_c_o)
    );

endmodule
